// File: rtl/noc_pkg.sv
// Shared types and width helpers for the NoC injection arbiter and router arbiters.
package noc_pkg;

  typedef enum logic {StIdle, StLocked} arb_state_e;

  // Counter must hold 0..depth inclusive.
  function automatic int unsigned credit_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [idx_width(NUM_REQ)-1:0]  index,
  output logic                           any
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  always_comb begin : p_pick
    int unsigned cand;
    cand  = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-locked round-robin sharing of one router injection port, with credit flow control.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned FLIT_WIDTH        = 128,
  parameter int unsigned DEST_WIDTH        = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH = 4
) (
  input  logic                                 clk_noc,
  input  logic                                 rst_noc_sync,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]   req_dest,
  input  logic [NUM_REQ-1:0]                   req_is_tail,
  output logic [FLIT_WIDTH-1:0]                data_out,
  output logic [DEST_WIDTH-1:0]                dest_out,
  output logic                                 is_tail_out,
  output logic                                 send_out,
  input  logic                                 credit_in,
  output logic [idx_width(NUM_REQ)-1:0]        grant_idx,
  output logic                                 busy,
  output logic                                 credit_err
);

  localparam int unsigned IdxW  = idx_width(NUM_REQ);
  localparam int unsigned CredW = credit_width(FLIT_BUFFER_DEPTH);
  localparam logic [CredW-1:0] CredMax = CredW'(FLIT_BUFFER_DEPTH);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [CredW-1:0]       credits_q, credits_d;
  logic                   credit_err_q, credit_err_d;
  logic [FLIT_WIDTH-1:0]  data_q, data_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic                   tail_q, tail_d;
  logic                   send_q, send_d;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [IdxW-1:0]        arb_index;
  logic                   arb_any;
  logic [IdxW-1:0]        acc_idx;
  logic                   accept;
  logic                   has_credit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .index(arb_index),
    .any  (arb_any)
  );

  // In LOCKED only the owner (held in grant_q) can be accepted.
  always_comb begin
    req_ready  = '0;
    acc_idx    = arb_index;
    has_credit = (credits_q != '0);
    if (state_q == StIdle) begin
      if (arb_any && has_credit) req_ready = arb_grant;
    end else begin
      acc_idx = grant_q;
      if (has_credit && req_valid[grant_q]) req_ready[grant_q] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    dest_d  = dest_q;
    tail_d  = tail_q;
    send_d  = 1'b0;
    if (accept) begin
      send_d  = 1'b1;
      data_d  = req_data[acc_idx];
      tail_d  = req_is_tail[acc_idx];
      grant_d = acc_idx;
      // Destination is taken from the head flit and held across the body.
      if (state_q == StIdle) dest_d = req_dest[acc_idx];
      if (req_is_tail[acc_idx]) begin
        state_d = StIdle;
        ptr_d   = (acc_idx == LastIdx) ? '0 : acc_idx + 1'b1;
      end else begin
        state_d = StLocked;
      end
    end
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (credit_in && !accept) begin
      if (credits_q == CredMax) credit_err_d = 1'b1;
      else                      credits_d    = credits_q + 1'b1;
    end else if (accept && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      grant_q      <= '0;
      credits_q    <= CredMax;
      credit_err_q <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
      tail_q       <= 1'b0;
      send_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tail_q       <= tail_d;
      send_q       <= send_d;
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q == StLocked);
  assign credit_err  = credit_err_q;

endmodule
